// File: rtl/wide_alu_sequencer_pkg.sv
// Shared opcode encodings and word-size constants for the wide ALU sequencer
// and the 16-bit ALU it drives.
package wide_alu_sequencer_pkg;

    localparam int WORD_SIZE = 32;
    localparam int HALF_SIZE = WORD_SIZE / 2;
    localparam int OP_WIDTH  = 4;

    typedef logic [OP_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_ADD = 4'h0;
    localparam opcode_t OP_SUB = 4'h1;
    localparam opcode_t OP_TCP = 4'h2;
    localparam opcode_t OP_NOT = 4'h3;
    localparam opcode_t OP_AND = 4'h4;
    localparam opcode_t OP_ORR = 4'h5;
    localparam opcode_t OP_SHL = 4'h6;
    localparam opcode_t OP_SHR = 4'h7;
    localparam opcode_t OP_LHI = 4'h8;

    // OP_LHI has an encoding but no two-pass sequence, so it is rejected.
    function automatic logic op_supported(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_TCP, OP_NOT,
            OP_AND, OP_ORR, OP_SHL, OP_SHR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic op_chained(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_TCP);
    endfunction

endpackage

// File: rtl/wide_alu_sequencer.sv
// Runs a 32-bit operation as two passes (low half, then high half) through an
// external 16-bit combinational ALU, chaining carry/borrow between the passes.
module wide_alu_sequencer
    import wide_alu_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_WIDTH-1:0]  req_op,
    input  logic [WORD_SIZE-1:0] req_a,
    input  logic [WORD_SIZE-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_c,
    output logic                 rsp_cout,
    output logic [1:0]           rsp_compare,
    output logic                 rsp_err,
    output logic [HALF_SIZE-1:0] alu_a,
    output logic [HALF_SIZE-1:0] alu_b,
    output logic                 alu_cin,
    output logic [OP_WIDTH-1:0]  alu_op,
    input  logic [HALF_SIZE-1:0] alu_c,
    input  logic                 alu_cout,
    input  logic [1:0]           alu_compare
);

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_RESP} state_t;

    state_t               r_state;
    opcode_t              r_op;
    logic [WORD_SIZE-1:0] r_a;
    logic [WORD_SIZE-1:0] r_b;
    logic [HALF_SIZE-1:0] r_lo_c;
    logic                 r_lo_cout;
    logic                 r_rsp_valid;
    logic [WORD_SIZE-1:0] r_rsp_c;
    logic                 r_rsp_cout;
    logic [1:0]           r_rsp_compare;
    logic                 r_rsp_err;

    logic                 w_in_lo;
    logic                 w_in_hi;
    logic [HALF_SIZE-1:0] w_a_half;
    logic [HALF_SIZE-1:0] w_b_half;
    logic [WORD_SIZE-1:0] w_result;
    logic                 w_cout;
    logic [1:0]           w_compare;
    logic                 w_unused_compare;

    assign w_in_lo  = (r_state == ST_LO);
    assign w_in_hi  = (r_state == ST_HI);
    assign w_a_half = w_in_hi ? r_a[WORD_SIZE-1:HALF_SIZE] : r_a[HALF_SIZE-1:0];
    assign w_b_half = w_in_hi ? r_b[WORD_SIZE-1:HALF_SIZE] : r_b[HALF_SIZE-1:0];

    // The ALU's own compare is per-half and meaningless for the full word.
    assign w_unused_compare = ^alu_compare;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_op  = OP_ADD;
        if (w_in_lo || w_in_hi) begin
            if (r_op == OP_TCP) begin
                alu_b  = w_a_half;
                alu_op = OP_SUB;
            end else begin
                alu_a  = w_a_half;
                alu_b  = w_b_half;
                alu_op = r_op;
            end
            alu_cin = w_in_hi && op_chained(r_op) && r_lo_cout;
        end
    end

    // Per-half shifts lose the bit that crosses the half boundary; restore it.
    always_comb begin
        w_result = {alu_c, r_lo_c};
        if (r_op == OP_SHL) w_result[HALF_SIZE]   = r_a[HALF_SIZE-1];
        if (r_op == OP_SHR) w_result[HALF_SIZE-1] = r_a[HALF_SIZE];
        w_cout    = ((r_op == OP_ADD) || (r_op == OP_SUB)) ? alu_cout : 1'b0;
        w_compare = 2'b00;
        if ((r_op == OP_SUB) && (w_result != '0))
            w_compare = {1'b1, w_result[WORD_SIZE-1]};
    end

    // NOTE: all sequential state uses non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_ADD;
            r_a           <= '0;
            r_b           <= '0;
            r_lo_c        <= '0;
            r_lo_cout     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_c       <= '0;
            r_rsp_cout    <= 1'b0;
            r_rsp_compare <= 2'b00;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op <= req_op;
                        r_a  <= req_a;
                        r_b  <= req_b;
                        if (op_supported(req_op)) begin
                            r_state <= ST_LO;
                        end else begin
                            r_rsp_c       <= '0;
                            r_rsp_cout    <= 1'b0;
                            r_rsp_compare <= 2'b00;
                            r_rsp_err     <= 1'b1;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= ST_RESP;
                        end
                    end
                end
                ST_LO: begin
                    r_lo_c    <= alu_c;
                    r_lo_cout <= alu_cout;
                    r_state   <= ST_HI;
                end
                ST_HI: begin
                    r_rsp_c       <= w_result;
                    r_rsp_cout    <= w_cout;
                    r_rsp_compare <= w_compare;
                    r_rsp_err     <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_c       = r_rsp_c;
    assign rsp_cout    = r_rsp_cout;
    assign rsp_compare = r_rsp_compare;
    assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Bench for wide_alu_sequencer: 16-bit ALU environment, 32-bit reference model
// with a per-cycle scoreboard, directed corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_wide_alu_sequencer;
    import wide_alu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_c;
    logic        rsp_cout;
    logic [1:0]  rsp_compare;
    logic        rsp_err;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [3:0]  alu_op;
    logic [15:0] alu_c;
    logic        alu_cout;
    logic [1:0]  alu_compare;
    logic [16:0] alu_t;

    int n_checks = 0;
    int n_fails  = 0;
    int ready_mode = 0;  // 0: rsp_ready high, 1: low, 2: random

    typedef struct {
        logic [31:0] c;
        logic        cout;
        logic [1:0]  cmp;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    wide_alu_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
        .rsp_cout(rsp_cout), .rsp_compare(rsp_compare), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_c(alu_c), .alu_cout(alu_cout), .alu_compare(alu_compare)
    );

    always #5 clk = ~clk;

    // 16-bit combinational ALU that sits beside the sequencer.
    always_comb begin
        alu_t    = '0;
        alu_c    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_t    = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
                alu_c    = alu_t[15:0];
                alu_cout = alu_t[16];
            end
            OP_SUB: begin
                alu_t    = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cin};
                alu_c    = alu_t[15:0];
                alu_cout = alu_t[16];
            end
            OP_NOT:  alu_c = ~alu_a;
            OP_AND:  alu_c = alu_a & alu_b;
            OP_ORR:  alu_c = alu_a | alu_b;
            OP_SHL:  alu_c = {alu_a[14:0], 1'b0};
            OP_SHR:  alu_c = {alu_a[15], alu_a[15:1]};
            default: alu_c = '0;
        endcase
        alu_compare = (alu_a == alu_b) ? 2'b00 : ((alu_a > alu_b) ? 2'b10 : 2'b11);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            if (n_fails <= 50)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference behaviour of each opcode.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        e.c = '0; e.cout = 1'b0; e.cmp = 2'b00; e.err = 1'b0; e.lat = 3; e.acc = 0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.c = s[31:0];
                e.cout = s[32];
            end
            OP_SUB: begin
                e.c = a - b;
                e.cout = (a < b);
                e.cmp = (e.c == 0) ? 2'b00 : {1'b1, e.c[31]};
            end
            OP_TCP: e.c = 32'd0 - a;
            OP_NOT: e.c = ~a;
            OP_AND: e.c = a & b;
            OP_ORR: e.c = a | b;
            OP_SHL: e.c = a << 1;
            OP_SHR: e.c = {a[31], a[31:1]};
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
        return e;
    endfunction

    task automatic check_alu_idle(input string tag);
        check({tag, "_alu_a"},   32'(alu_a),   32'd0);
        check({tag, "_alu_b"},   32'(alu_b),   32'd0);
        check({tag, "_alu_cin"}, 32'(alu_cin), 32'd0);
        check({tag, "_alu_op"},  32'(alu_op),  32'(OP_ADD));
    endtask

    // Scoreboard: one compare per falling edge against the reference model.
    initial begin
        exp_t        e;
        bit          in_resp = 1'b0;
        logic [31:0] h_c;
        logic        h_cout;
        logic [1:0]  h_cmp;
        logic        h_err;
        int          ncnt = 0;
        forever begin
            @(negedge clk);
            ncnt++;
            if (reset) begin
                sb.delete();
                in_resp = 1'b0;
                check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                check("req_ready", 32'(req_ready), 32'(sb.size() == 0));
                if (rsp_valid) begin
                    check_alu_idle("resp");
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = sb[0];
                        if (!in_resp) begin
                            check("rsp_latency", 32'(ncnt - e.acc), 32'(e.lat));
                            in_resp = 1'b1;
                            h_c = rsp_c; h_cout = rsp_cout; h_cmp = rsp_compare; h_err = rsp_err;
                        end else begin
                            check("hold_c", rsp_c, h_c);
                            check("hold_misc", 32'({rsp_cout, rsp_compare, rsp_err}),
                                  32'({h_cout, h_cmp, h_err}));
                        end
                        check("rsp_c",       rsp_c,              e.c);
                        check("rsp_cout",    32'(rsp_cout),      32'(e.cout));
                        check("rsp_compare", 32'(rsp_compare),   32'(e.cmp));
                        check("rsp_err",     32'(rsp_err),       32'(e.err));
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            in_resp = 1'b0;
                        end
                    end
                end else if (sb.size() == 0) begin
                    check_alu_idle("idle");
                end else if (ncnt - sb[0].acc > sb[0].lat) begin
                    check("rsp_deadline", 32'(rsp_valid), 32'd1);
                    void'(sb.pop_front());
                end
                if (req_valid && req_ready) begin
                    e = model(req_op, req_a, req_b);
                    e.acc = ncnt;
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output time t_acc);
        bit ok = 1'b0;
        t_acc = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (req_ready && !reset) begin
                ok = 1'b1;
                t_acc = $time;
            end
        end
        if (!ok) check("accept_timeout", 32'(req_ready), 32'd1);
        else @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] xc, input logic xcout,
                            input logic [1:0] xcmp, input logic xerr, input int xlat);
        time t;
        int  k = 0;
        send(op, a, b, t);
        for (int i = 1; i <= 8 && k == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) k = i;
        end
        check({name, "_lat"},  32'(k),           32'(xlat));
        check({name, "_c"},    rsp_c,            xc);
        check({name, "_cout"}, 32'(rsp_cout),    32'(xcout));
        check({name, "_cmp"},  32'(rsp_compare), 32'(xcmp));
        check({name, "_err"},  32'(rsp_err),     32'(xerr));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_FFFF;
            4:       return 32'h0000_8000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        time         t1, t2;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready",   32'(req_ready),   32'd1);
        check("reset_rsp_valid",   32'(rsp_valid),   32'd0);
        check("reset_rsp_c",       rsp_c,            32'd0);
        check("reset_rsp_cout",    32'(rsp_cout),    32'd0);
        check("reset_rsp_compare", 32'(rsp_compare), 32'd0);
        check("reset_rsp_err",     32'(rsp_err),     32'd0);
        @(posedge clk);
        #1;

        directed("add_carry16", OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 2'b00, 1'b0, 3);
        directed("add_carry32", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 3);
        directed("sub_borrow",  OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 2'b11, 1'b0, 3);
        directed("sub_equal",   OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3);
        directed("sub_greater", OP_SUB, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 2'b10, 1'b0, 3);
        directed("shl_cross",   OP_SHL, 32'h0000_8000, 32'h0000_0000, 32'h0001_0000, 1'b0, 2'b00, 1'b0, 3);
        directed("shr_cross",   OP_SHR, 32'h8001_0000, 32'h0000_0000, 32'hC000_8000, 1'b0, 2'b00, 1'b0, 3);
        directed("tcp_one",     OP_TCP, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 2'b00, 1'b0, 3);
        directed("and_halves",  OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 2'b00, 1'b0, 3);
        directed("lhi_err",     OP_LHI, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 1);

        // Back-to-back requests: one accept every four cycles.
        send(OP_ADD, 32'h1, 32'h2, t1);
        send(OP_ORR, 32'h3, 32'h4, t2);
        check("throughput_cycles", 32'((t2 - t1) / 10), 32'd4);
        repeat (6) @(posedge clk);
        #1;

        // Consumer stalls for five cycles with a competing request present.
        ready_mode = 1;
        send(OP_ADD, 32'h3, 32'h4, t1);
        for (int i = 0; i < 8 && !rsp_valid; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b1; req_op = OP_SUB; req_a = 32'h9; req_b = 32'h1;
        repeat (5) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_c",     rsp_c,          32'h7);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0; ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while the high half is in flight.
        send(OP_ADD, 32'h1234_5678, 32'h1111_1111, t1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        directed("after_reset", OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 2'b00, 1'b0, 3);

        // Reset while a stalled response is pending.
        ready_mode = 1;
        send(OP_LHI, 32'h0, 32'h0, t1);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("resprst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; ready_mode = 0;
        @(posedge clk);
        #1;

        ready_mode = 2;
        for (int n = 0; n < 250; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            a  = pick();
            b  = ($urandom_range(0, 5) == 0) ? a : pick();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(op, a, b, t1);
        end
        ready_mode = 0;
        for (int i = 0; i < 30 && (sb.size() != 0 || rsp_valid); i++) @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
